fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
Instruction-fetch stage directly downstream of program_counter.
- Takes the current PC and issues one word read at a time to instruction memory over a req/ack handshake.
- Pairs each returned instruction with its PC and queues the pair in a small FIFO.
- Presents queued pairs to decode over valid/ready, and pulses pc_advance so the PC steps to PC+4 only when a fetch has actually completed.

Parameters:
DATA_W, 32, width of PC, memory address and instruction word
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
pc_in  in  DATA_W  current PC from program_counter
pc_advance  out  1  one-cycle enable to program_counter: load PC+4
flush  in  1  redirect; discard queued and in-flight fetches
mem_req  out  1  read request, held until mem_ack
mem_addr  out  DATA_W  word-aligned read address
mem_ack  in  1  read data valid, only meaningful while mem_req=1
mem_rdata  in  DATA_W  instruction word
if_valid  out  1  head entry available to decode
if_ready  in  1  decode accepts head entry
if_instr  out  DATA_W  head instruction
if_pc  out  DATA_W  PC of head instruction
fifo_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE.
  - Outputs: mem_req=0, mem_addr=0, fifo_count=0, if_valid=0, if_instr=0, if_pc=0, pc_advance=0.
  - Reset overrides flush and all handshakes.
  - Reset mid-request drops mem_req the next cycle; the late ack is ignored.
- FSM states: IDLE, REQ, DRAIN.
- IDLE:
  - If flush=0 and fifo_count<DEPTH: register mem_addr={pc_in[DATA_W-1:2],2'b00}, set mem_req=1, go to REQ.
  - Otherwise stay in IDLE with mem_req=0.
- REQ:
  - mem_req=1, mem_addr held stable.
  - mem_ack=1 and flush=0: push {mem_addr, mem_rdata}; pc_advance=1 combinationally this cycle; go to IDLE.
  - mem_ack=1 and flush=1: data dropped, pc_advance=0, go to IDLE.
  - mem_ack=0 and flush=1: go to DRAIN.
  - mem_ack=0 and flush=0: stay in REQ.
- DRAIN:
  - mem_req stays 1; the bus cannot abort a request.
  - On mem_ack: data dropped, pc_advance=0, go to IDLE.
  - Further flushes have no additional effect.
- pc_advance is asserted only in REQ with mem_ack=1 and flush=0; it is never high in any other state.
- Throughput and latency:
  - At most one outstanding request.
  - With zero-wait memory (ack in the first REQ cycle), one fetch completes every 2 cycles.
  - An entry pushed at edge N is visible (if_valid=1) in the cycle after edge N.
- FIFO:
  - if_valid = (fifo_count!=0); if_instr and if_pc come from the head entry, and are 0 when empty.
  - Pop occurs on if_valid & if_ready & !flush.
  - Simultaneous push and pop: fifo_count unchanged, order preserved.
  - Space is reserved at issue (issue only when fifo_count<DEPTH), so a push never meets a full FIFO; overflow is impossible.
  - Pointers wrap modulo DEPTH.
- Flush: clears the FIFO at the same edge (fifo_count=0 next cycle), overriding any push or pop in that cycle. No issue occurs in a flush cycle.
- Misaligned pc_in: low two bits are ignored for mem_addr; if_pc carries the aligned address.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding IDLE/REQ/DRAIN
  - DATA_W default
  - entry width 2*DATA_W
  - reset constants (zero)
- One sub-module, fetch_fifo: synchronous FIFO of DEPTH x 2*DATA_W with push, pop, clear, count, head-data outputs.
- The FSM and handshake logic stay in fetch_buffer.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_ack=1 and flush=1 -> all outputs 0, fifo_count=0; first mem_req=1 appears 1 cycle after rst=1, with mem_addr=pc_in (e.g. 0x00000000).
- Zero-wait stream: memory acks every request, mem_rdata=0x20080000+addr, if_ready=1 -> mem_addr sequence 0,4,8,12; pc_advance pulses once per 2 cycles; if_pc/if_instr pairs 0/0x20080000, 4/0x20080004 in order.
- Backpressure: if_ready=0 -> exactly 4 fetches complete, fifo_count=4, mem_req stays 0, no further pc_advance. Then if_ready=1 for one cycle -> count 3, next request issued.
- Wait states: ack delayed 3 cycles -> mem_req and mem_addr stable for all 4 REQ cycles; single pc_advance pulse in the ack cycle.
- Flush in flight: flush while in REQ with ack arriving 2 cycles later -> mem_req stays 1 through DRAIN, returned word not queued, pc_advance=0, FIFO empty. The next request uses the new pc_in (e.g. 0x00000100).
- Flush with simultaneous ack/pop: flush, mem_ack and if_ready all high with fifo_count=2 -> next cycle fifo_count=0, if_valid=0, pc_advance was 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Rev 1.0
// ------------------------------------------------------------------
package fetch_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int                    ENTRY_W_DEF = 2 * DATA_W_DEF;
    localparam logic [DATA_W_DEF-1:0] RST_ADDR    = '0;
    localparam state_t                RST_STATE   = ST_IDLE;

    function automatic int entry_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_fifo: DEPTH-entry synchronous FIFO with clear, count and head data.
// Rev 1.0
// ------------------------------------------------------------------
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst && !clear_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o     = count_q;
    assign head_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_buffer: issues one word fetch at a time from pc_in, queues {pc, instr} for decode.
// Rev 1.0
// ------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 4,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    output logic              pc_advance,
    input  logic              flush,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_pc,
    output logic [CW-1:0]     fifo_count
);

    localparam int            ENTRY_W = entry_width(DATA_W);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic                unused_pc_lsb;

    assign unused_pc_lsb = ^pc_in[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RST_STATE;
            addr_q  <= DATA_W'(RST_ADDR);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Space is reserved at issue, so the later push can never overflow the FIFO.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && (fifo_count < DEPTH_C)) begin
                    addr_d  = {pc_in[DATA_W-1:2], 2'b00};
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack)    state_d = ST_IDLE;
                else if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = (state_q != ST_IDLE);
        pc_advance = rst && (state_q == ST_REQ) && mem_ack && !flush;
    end

    assign mem_addr = addr_q;
    assign push     = pc_advance;
    assign if_valid = (fifo_count != '0);
    assign pop      = if_valid && if_ready && !flush;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({addr_q, mem_rdata}),
        .pop_i       (pop),
        .clear_i     (flush),
        .count_o     (fifo_count),
        .head_data_o (head)
    );

    assign if_pc    = head[ENTRY_W-1:DATA_W];
    assign if_instr = head[DATA_W-1:0];

endmodule
`default_nettype wire
